// File: rtl/preg_regfile.sv
// rtl/preg_regfile.sv - picoMIPS register file, two combinational read ports, one write port
//
// Optional feature: define PREG_BYPASS_EN to forward Wdata onto the read
// ports during a write cycle. Default build reads stored contents only.
// Register 0 always reads zero and is never written.

module preg_regfile #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  nReset,
   input  logic [ADDR_WIDTH-1:0] Rd,
   input  logic [ADDR_WIDTH-1:0] Rs,
   input  logic [ADDR_WIDTH-1:0] Rt,
   input  logic [DATA_WIDTH-1:0] Wdata,
   input  logic [1:0]            ctrl,
   output logic [DATA_WIDTH-1:0] Rd_data,
   output logic [DATA_WIDTH-1:0] Rs_data
);

   localparam int NUM_REGS = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic                  treg;
   logic                  write_en;
   logic                  write_live;
   logic [DATA_WIDTH-1:0] stored_a;
   logic [DATA_WIDTH-1:0] stored_s;

   assign treg     = ctrl[1];
   assign write_en = ctrl[0];

   // Destination / first-operand address: Rt when treg is set, otherwise Rd
   assign sel_addr = treg ? Rt : Rd;

   // Writes to register 0 are discarded so it stays hard-wired to zero
   assign write_live = write_en && (sel_addr != '0);

   // Register array: async clear on reset, single write port on rising edge
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (write_live) begin
         regs[sel_addr] <= Wdata;
      end
   end

   // Stored-value reads; address 0 is forced to zero regardless of storage
   always_comb begin
      stored_a = '0;
      stored_s = '0;
      if (sel_addr != '0) begin
         stored_a = regs[sel_addr];
      end
      if (Rs != '0) begin
         stored_s = regs[Rs];
      end
   end

`ifdef PREG_BYPASS_EN
   // Forward the incoming write data to any port addressing the written register
   always_comb begin
      Rd_data = stored_a;
      Rs_data = stored_s;
      if (write_live) begin
         Rd_data = Wdata;
         if (Rs == sel_addr) begin
            Rs_data = Wdata;
         end
      end
   end
`else
   // Reads return stored contents only; a write shows up after the clock edge
   always_comb begin
      Rd_data = stored_a;
      Rs_data = stored_s;
   end
`endif

endmodule

// File: tb/tb_preg_regfile.sv
// tb/tb_preg_regfile.sv - directed table-driven bench for preg_regfile

module tb_preg_regfile;

   logic       clk;
   logic       nReset;
   logic [4:0] Rd;
   logic [4:0] Rs;
   logic [4:0] Rt;
   logic [7:0] Wdata;
   logic [1:0] ctrl;
   logic [7:0] Rd_data;
   logic [7:0] Rs_data;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [4:0] rd;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [7:0] wdata;
      logic [1:0] ctrl;
      logic [7:0] exp_rd;
      logic [7:0] exp_rs;
   } vec_t;

   vec_t tbl [13];
   logic [7:0] model [32];

   preg_regfile #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
      .clk(clk),
      .nReset(nReset),
      .Rd(Rd),
      .Rs(Rs),
      .Rt(Rt),
      .Wdata(Wdata),
      .ctrl(ctrl),
      .Rd_data(Rd_data),
      .Rs_data(Rs_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   // drive on falling edge, clock it in, sample 1 time unit after the rising edge
   task automatic step(input logic [4:0] rd_i, input logic [4:0] rs_i, input logic [4:0] rt_i,
                       input logic [7:0] wd_i, input logic [1:0] c_i);
      @(negedge clk);
      Rd = rd_i;
      Rs = rs_i;
      Rt = rt_i;
      Wdata = wd_i;
      ctrl = c_i;
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      Rd = '0; Rs = '0; Rt = '0; Wdata = '0; ctrl = 2'b00;
      nReset = 1'b0;

      tbl[0]  = '{5'd3,  5'd3,  5'd0,  8'h5A, 2'b01, 8'h5A, 8'h5A};
      tbl[1]  = '{5'd0,  5'd3,  5'd0,  8'hFF, 2'b01, 8'h00, 8'h5A};
      tbl[2]  = '{5'd2,  5'd9,  5'd0,  8'h11, 2'b01, 8'h11, 8'h00};
      tbl[3]  = '{5'd9,  5'd2,  5'd0,  8'hEE, 2'b01, 8'hEE, 8'h11};
      tbl[4]  = '{5'd2,  5'd9,  5'd0,  8'h77, 2'b00, 8'h11, 8'hEE};
      tbl[5]  = '{5'd0,  5'd0,  5'd7,  8'hA5, 2'b11, 8'hA5, 8'h00};
      tbl[6]  = '{5'd0,  5'd7,  5'd7,  8'h33, 2'b10, 8'hA5, 8'hA5};
      tbl[7]  = '{5'd7,  5'd0,  5'd0,  8'h44, 2'b10, 8'h00, 8'h00};
      tbl[8]  = '{5'd31, 5'd31, 5'd0,  8'hC3, 2'b01, 8'hC3, 8'hC3};
      tbl[9]  = '{5'd1,  5'd31, 5'd31, 8'h12, 2'b11, 8'h12, 8'h12};
      tbl[10] = '{5'd31, 5'd3,  5'd0,  8'h00, 2'b00, 8'h12, 8'h5A};
      tbl[11] = '{5'd3,  5'd3,  5'd9,  8'h99, 2'b10, 8'hEE, 8'h5A};
      tbl[12] = '{5'd0,  5'd0,  5'd0,  8'hAB, 2'b01, 8'h00, 8'h00};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_rd", Rd_data, 8'h00);
      check("reset_rs", Rs_data, 8'h00);
      @(negedge clk);
      nReset = 1'b1;

      // no-write sweep
      for (int i = 1; i < 32; i++) begin
         step(5'(i), 5'(i), 5'(i), 8'(i * 37 + 5), 2'b00);
         check("nowrite_rd", Rd_data, 8'h00);
         check("nowrite_rs", Rs_data, 8'h00);
      end

      // directed vector table
      for (int k = 0; k < 13; k++) begin
         step(tbl[k].rd, tbl[k].rs, tbl[k].rt, tbl[k].wdata, tbl[k].ctrl);
         check($sformatf("vec%0d_rd", k), Rd_data, tbl[k].exp_rd);
         check($sformatf("vec%0d_rs", k), Rs_data, tbl[k].exp_rs);
      end

      // asynchronous reset mid-cycle clears without a clock edge
      @(negedge clk);
      Rd = 5'd3; Rs = 5'd3; ctrl = 2'b00;
      #1;
      check("prereset_rd", Rd_data, 8'h5A);
      #1;
      nReset = 1'b0;
      #1;
      check("async_reset_rd", Rd_data, 8'h00);
      check("async_reset_rs", Rs_data, 8'h00);
      // writes blocked while reset held
      ctrl = 2'b01; Wdata = 8'h66;
      @(posedge clk);
      #1;
      check("reset_block_wr", Rd_data, 8'h00);
      @(negedge clk);
      nReset = 1'b1;
      @(posedge clk);
      #1;
      check("first_edge_wr", Rd_data, 8'h66);

      // full write/readback sweep
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 256; j++) begin
            step(5'(i), 5'(i), 5'd0, 8'(j), 2'b01);
            check("wr_rd", Rd_data, (i == 0) ? 8'h00 : 8'(j));
            check("wr_rs", Rs_data, (i == 0) ? 8'h00 : 8'(j));
         end
      end

      // load distinct values, then treg read-only sweep
      model[0] = 8'h00;
      for (int i = 1; i < 32; i++) begin
         model[i] = 8'(i * 3 + 1);
         step(5'(i), 5'd0, 5'd0, model[i], 2'b01);
      end
      for (int i = 0; i < 32; i++) begin
         step(5'd0, 5'(i), 5'(i), 8'(255 - i), 2'b10);
         check("treg_ro_rd", Rd_data, model[i]);
         check("treg_ro_rs", Rs_data, model[i]);
      end
      for (int i = 0; i < 32; i++) begin
         step(5'(i), 5'(31 - i), 5'd0, 8'h00, 2'b00);
         check("unchanged_rd", Rd_data, model[i]);
         check("unchanged_rs", Rs_data, model[31 - i]);
      end

      // dual-port independence and same-cycle forwarding
      step(5'd2, 5'd0, 5'd0, 8'h11, 2'b01);
      step(5'd9, 5'd0, 5'd0, 8'hEE, 2'b01);
      step(5'd2, 5'd9, 5'd0, 8'h00, 2'b00);
      check("dual_rd", Rd_data, 8'h11);
      check("dual_rs", Rs_data, 8'hEE);
      @(negedge clk);
      Rd = 5'd9; Rs = 5'd9; Wdata = 8'h3C; ctrl = 2'b01;
      #1;
`ifdef PREG_BYPASS_EN
      check("bypass_rd", Rd_data, 8'h3C);
      check("bypass_rs", Rs_data, 8'h3C);
`else
      check("nobypass_rd", Rd_data, 8'hEE);
      check("nobypass_rs", Rs_data, 8'hEE);
`endif
      @(posedge clk);
      #1;
      check("after_edge_rs", Rs_data, 8'h3C);
      @(negedge clk);
      Rd = 5'd0; Rs = 5'd0; ctrl = 2'b00;
      #1;
      check("reg0_rd", Rd_data, 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/preg_regfile.md
Name: preg_regfile

Overview:
- picoMIPS general-purpose register file: 2^ADDR_WIDTH registers of DATA_WIDTH bits, two combinational read ports, one synchronous write port.
- Sits between instruction decode and the ALU.
- Register 0 is hard-wired to zero.
- A 2-bit control word selects whether the destination/first-operand address comes from Rd or Rt, and whether a write occurs.

Parameters:
- DATA_WIDTH, 8, width of each register and of the data ports.
- ADDR_WIDTH, 5, register address width; the file holds 2^ADDR_WIDTH registers.

Ports:
- clk  input  1  clock; all register updates on rising edge.
- nReset  input  1  asynchronous active-low reset; clears all registers.
- Rd  input  ADDR_WIDTH  destination / first-operand register address (used when treg=0).
- Rs  input  ADDR_WIDTH  second-operand register address.
- Rt  input  ADDR_WIDTH  alternate destination / first-operand address (used when treg=1).
- Wdata  input  DATA_WIDTH  write data.
- ctrl  input  2  {treg, write}; ctrl[1]=treg, ctrl[0]=write enable.
- Rd_data  output  DATA_WIDTH  contents of the selected destination register.
- Rs_data  output  DATA_WIDTH  contents of register Rs.

Behaviour:
- Address select:
  - A = ctrl[1] ? Rt : Rd.
  - A is used both for the write address and for the Rd_data read address.
- Read:
  - Rd_data = reg[A]; Rs_data = reg[Rs].
  - Purely combinational, zero latency.
  - Address 0 always reads 0.
- Write:
  - On rising clk with nReset=1 and ctrl[0]=1, reg[A] <= Wdata.
  - Written value becomes visible on read ports after the edge (no same-cycle bypass unless the optional feature is enabled).
- Register 0:
  - Writes to address 0 are ignored; it is never stored.
- ctrl=2'b00 or 2'b10: no state change; outputs only reflect the read addresses.
- Reset:
  - nReset low asynchronously clears registers 1..2^ADDR_WIDTH-1 to 0, hence both outputs read 0 for any address.
  - Writes are blocked while nReset is low.
  - Release is synchronised by the clock edge: the first write occurs on the first rising edge with nReset high.
- Rd and Rs may address the same register: both ports return identical data.
- Upper address wrap: addresses cover the full 2^ADDR_WIDTH range exactly; no out-of-range case exists.
- Outputs contain no X after reset, and none from X-free inputs.

Optional Feature:
- Macro PREG_BYPASS_EN.
- Defined: write-forwarding. While ctrl[0]=1 and A≠0:
  - Rd_data returns Wdata combinationally.
  - Rs_data returns Wdata if Rs==A.
  - All other reads are unchanged.
- Undefined: reads always return stored contents; the new value appears only after the clock edge.

Test Plan:
- Reset check: assert nReset=0 mid-simulation after writing reg 3=0x5A -> Rd_data and Rs_data read 0 for Rd=Rs=3 immediately, without waiting for a clock edge.
- No-write sweep: ctrl=2'b00, sweep Rd=Rs=1..31 and Wdata=0..255 each cycle -> all reads stay 0.
- Write/readback: ctrl=2'b01, Rd=Rs=i, Wdata=j for all i, j -> after each edge both Rd_data and Rs_data equal j for i≠0; address 0 always reads 0.
- treg path: ctrl=2'b11, Rd=0, Rt=7, Wdata=0xA5, then ctrl=2'b10, Rs=7 -> Rd_data=0xA5 and Rs_data=0xA5; register 0 is still 0.
- treg read-only: ctrl=2'b10, Rd=0, Rt=Rs=i, with Wdata varying -> Rd_data=Rs_data=value stored earlier in reg i; no register changes.
- Dual-port independence: reg 2=0x11, reg 9=0xEE; Rd=2, Rs=9, ctrl=2'b00 -> Rd_data=0x11, Rs_data=0xEE. With PREG_BYPASS_EN, ctrl=2'b01, Rd=9, Wdata=0x3C -> Rs_data=0x3C in the same cycle.
